tx_frame_decoder: RTL

- Reads the framed byte stream that the tx path writes: one header byte, then MSB, then LSB.
- Pops bytes from the read side of a byte fifo, checks each header, and rebuilds each frame as a 16-bit word tagged with a 2-bit source id.
- Presents the result on a data_avail/data_accept handshake.
- Used for on-chip loopback self-test of the tx path, and as the frame reader in benches.

---
 rtl/tx_frame_decoder.sv | 109 ++++++++++
 1 files changed

// File: rtl/tx_frame_decoder.sv
// rtl/tx_frame_decoder.sv - rebuilds {hdr, msb, lsb} byte frames from a fifo into tagged 16-bit words
module tx_frame_decoder #(
   parameter logic [7:0]  HDR_MASK  = 8'hFC,
   parameter logic [7:0]  HDR_MATCH = 8'hA0,
   parameter logic [15:0] TIMEOUT   = 16'd1000,
   parameter int          ERR_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rdata,
   input  logic             rempty,
   output logic             rinc,
   output logic [15:0]      data_out,
   output logic [1:0]       src_out,
   output logic             data_avail,
   input  logic             data_accept,
   output logic [ERR_W-1:0] err_cnt,
   output logic             err_pulse,
   output logic             busy
);

   typedef enum logic [1:0] {S_HDR, S_MSB, S_LSB, S_OUT} state_t;

   state_t      state, state_nx;
   logic [15:0] timer, timer_nx;
   logic [1:0]  src, src_nx;
   logic [7:0]  msb, msb_nx;
   logic        pop, err, load_out;

   always_comb begin
      state_nx = state;
      timer_nx = timer;
      src_nx   = src;
      msb_nx   = msb;
      pop      = 1'b0;
      err      = 1'b0;
      load_out = 1'b0;
      case (state)
         S_HDR: begin
            if (!rempty) begin
               pop = 1'b1;
               if ((rdata & HDR_MASK) == HDR_MATCH) begin
                  src_nx   = rdata[1:0];
                  timer_nx = 16'd0;
                  state_nx = S_MSB;
               end else begin
                  err = 1'b1;
               end
            end
         end
         S_MSB, S_LSB: begin
            if (!rempty) begin
               pop      = 1'b1;
               timer_nx = 16'd0;
               if (state == S_MSB) begin
                  msb_nx   = rdata;
                  state_nx = S_LSB;
               end else begin
                  load_out = 1'b1;
                  state_nx = S_OUT;
               end
            end else if (timer == TIMEOUT - 16'd1) begin
               // Starved mid-frame: drop it and look for the next header
               err      = 1'b1;
               timer_nx = 16'd0;
               state_nx = S_HDR;
            end else begin
               timer_nx = timer + 16'd1;
            end
         end
         S_OUT: begin
            if (data_accept) state_nx = S_HDR;
         end
         default: state_nx = S_HDR;
      endcase
   end

   // Gated by rst so the combinational strobes read as cleared while reset is held
   assign rinc      = pop & ~rst;
   assign err_pulse = err & ~rst;
   assign busy      = (state != S_HDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_HDR;
         timer      <= 16'd0;
         src        <= 2'd0;
         msb        <= 8'd0;
         data_out   <= 16'd0;
         src_out    <= 2'd0;
         data_avail <= 1'b0;
         err_cnt    <= '0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
         src   <= src_nx;
         msb   <= msb_nx;
         if (load_out) begin
            data_out   <= {msb, rdata};
            src_out    <= src;
            data_avail <= 1'b1;
         end else if (state == S_OUT && data_accept) begin
            data_avail <= 1'b0;
         end
         if (err && err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
      end
   end

endmodule
